// File: rtl/alpha_frame_tx.sv
// alpha_frame_tx: ping-pong frame buffer feeding the case-4 detector core.
// One header beat (H_row + y), then A column beats with tlast on the last.
module alpha_frame_tx #(
  parameter int J         = 4,
  parameter int A         = 4,
  parameter int DATAWIDTH = 8,
  parameter int MIN_GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [$clog2(J):0]     wr_j,
  input  logic [A*DATAWIDTH-1:0] wr_data,
  input  logic [J*64-1:0]        wr_H_row,
  input  logic [127:0]           wr_y,
  input  logic                   wr_commit,
  output logic                   wr_ready,
  output logic [J*64-1:0]        H_row,
  output logic                   H_row_tvalid,
  output logic [127:0]           y,
  output logic                   y_tvalid,
  output logic [J*DATAWIDTH-1:0] alpha_u_col,
  output logic                   alpha_u_col_tvalid,
  output logic                   alpha_u_col_tlast,
  input  logic                   alpha_u_col_tready,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            frame_cnt
);

  localparam int JW = $clog2(J) + 1;
  localparam int AW = (A > 1) ? $clog2(A) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {IDLE, HDR, COL, GAP} state_t;

  state_t state_q, state_d;

  logic [DATAWIDTH-1:0] mem_q [2][J][A];
  logic [J*64-1:0]      hmem_q [2];
  logic [127:0]         ymem_q [2];

  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [AW-1:0] a_q, a_d;
  logic [GW-1:0] g_q, g_d;
  logic [15:0]   cnt_q;
  logic          ovf_q;

  logic [J*64-1:0]        hdr_q;
  logic [127:0]           y_q;
  logic [J*DATAWIDTH-1:0] col_q, col_src;

  logic do_wr, do_cm, ld_hdr, ld_col, cnt_inc;
  logic [JW-2:0] wj;

  assign wr_ready = ~full_q[wb_q];
  assign wj       = wr_j[JW-2:0];
  assign do_wr    = wr_en & wr_ready & (wr_j < JW'(J));
  assign do_cm    = wr_commit & wr_ready;

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int a = 0; a < A; a++)
        mem_q[wb_q][wj][a] <= wr_data[a*DATAWIDTH +: DATAWIDTH];
    end
    if (do_cm) begin
      hmem_q[wb_q] <= wr_H_row;
      ymem_q[wb_q] <= wr_y;
    end
  end

  always_comb begin
    col_src = '0;
    for (int j = 0; j < J; j++)
      col_src[j*DATAWIDTH +: DATAWIDTH] = mem_q[rb_q][j][a_d];
  end

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    a_d     = a_q;
    g_d     = g_q;
    ld_hdr  = 1'b0;
    ld_col  = 1'b0;
    cnt_inc = 1'b0;
    if (do_cm) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    unique case (state_q)
      IDLE: begin
        if (full_q[rb_q]) begin
          state_d = HDR;
          ld_hdr  = 1'b1;
        end
      end
      HDR: begin
        state_d = COL;
        a_d     = '0;
        ld_col  = 1'b1;
      end
      COL: begin
        if (alpha_u_col_tready) begin
          if (a_q == AW'(A - 1)) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            cnt_inc      = 1'b1;
            g_d          = '0;
            state_d      = (MIN_GAP == 0) ? IDLE : GAP;
          end else begin
            a_d    = a_q + AW'(1);
            ld_col = 1'b1;
          end
        end
      end
      GAP: begin
        if (g_q == GW'(MIN_GAP - 1)) state_d = IDLE;
        else g_d = g_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q  <= '0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      a_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hdr_q   <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      a_q     <= a_d;
      g_q     <= g_d;
      if (cnt_inc) cnt_q <= cnt_q + 16'd1;
      if ((wr_en | wr_commit) & ~wr_ready) ovf_q <= 1'b1;
      if (ld_hdr) begin
        hdr_q <= hmem_q[rb_q];
        y_q   <= ymem_q[rb_q];
      end
      if (ld_col) col_q <= col_src;
    end
  end

  assign H_row              = hdr_q;
  assign y                  = y_q;
  assign H_row_tvalid       = (state_q == HDR);
  assign y_tvalid           = (state_q == HDR);
  assign alpha_u_col        = col_q;
  assign alpha_u_col_tvalid = (state_q == COL);
  assign alpha_u_col_tlast  = (state_q == COL) && (a_q == AW'(A - 1));
  assign busy               = (state_q != IDLE);
  assign overflow           = ovf_q;
  assign frame_cnt          = cnt_q;

endmodule

// File: tb/tb_alpha_frame_tx.sv
// Scoreboard bench for alpha_frame_tx: stimulus queues expected headers
// and beats, a negedge monitor pops and compares what the DUT presents.
module tb_alpha_frame_tx;

  localparam int J = 4;
  localparam int A = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_commit, tready;
  logic [2:0]    wr_j;
  logic [31:0]   wr_data;
  logic [255:0]  wr_H_row;
  logic [127:0]  wr_y;
  logic          wr_ready, H_row_tvalid, y_tvalid;
  logic [255:0]  H_row;
  logic [127:0]  y;
  logic [31:0]   alpha_u_col;
  logic          col_tvalid, col_tlast, busy, overflow;
  logic [15:0]   frame_cnt;

  alpha_frame_tx dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_j(wr_j), .wr_data(wr_data),
    .wr_H_row(wr_H_row), .wr_y(wr_y), .wr_commit(wr_commit),
    .wr_ready(wr_ready),
    .H_row(H_row), .H_row_tvalid(H_row_tvalid),
    .y(y), .y_tvalid(y_tvalid),
    .alpha_u_col(alpha_u_col), .alpha_u_col_tvalid(col_tvalid),
    .alpha_u_col_tlast(col_tlast), .alpha_u_col_tready(tready),
    .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] h;
    logic [127:0] y;
  } hdr_t;

  hdr_t        hq[$];
  logic [32:0] bq[$];

  int pass = 0, total = 0;
  int cyc = 0;
  int hdr_cyc = 0, last_cyc = 0, hdr_gap = 0;
  int beats = 0, acc = 0, stall_cnt = 0;
  int c_edge = 0;
  bit in_frame = 0, stalled = 0;
  logic [32:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic logic [31:0] row(input logic [7:0] b, input int j);
    logic [31:0] r;
    for (int a = 0; a < A; a++) r[a*8 +: 8] = b + 8'(16 * j + a);
    return r;
  endfunction

  function automatic logic [31:0] col(input logic [7:0] b, input int a);
    logic [31:0] c;
    for (int j = 0; j < J; j++) c[j*8 +: 8] = b + 8'(16 * j + a);
    return c;
  endfunction

  function automatic logic [255:0] hdr(input logic [7:0] b);
    logic [255:0] r;
    for (int j = 0; j < J; j++)
      r[j*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(b) | (64'(j) << 8);
    return r;
  endfunction

  function automatic logic [127:0] yv(input logic [7:0] b);
    return {64'h1234_5678_9ABC_DEF0, 56'h0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rows(input logic [7:0] b);
    for (int j = 0; j < J; j++) begin
      wr_en = 1'b1; wr_j = 3'(j); wr_data = row(b, j);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic commit(input logic [7:0] b);
    wr_commit = 1'b1; wr_H_row = hdr(b); wr_y = yv(b);
    c_edge = cyc + 1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic push_hdr(input logic [7:0] b);
    hq.push_back('{h: hdr(b), y: yv(b)});
  endtask

  task automatic push_frame(input logic [7:0] b);
    push_hdr(b);
    for (int a = 0; a < A; a++) bq.push_back({a == A - 1, col(b, a)});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; beats = 0; stalled = 0;
    end else begin
      if (H_row_tvalid) begin
        hdr_t e;
        chk("y_tvalid", y_tvalid, 1);
        chk("hdr_alone", col_tvalid, 0);
        chk("hdr_order", in_frame, 0);
        hdr_gap = cyc - last_cyc;
        hdr_cyc = cyc;
        if (hq.size() == 0) begin
          total++;
          $display("FAIL hdr_unexpected: got %0h expected none", H_row);
        end else begin
          e = hq.pop_front();
          chk("H_row", H_row, e.h);
          chk("y", y, e.y);
        end
        in_frame = 1; beats = 0;
      end
      if (col_tvalid) begin
        if (stalled) chk("stall_hold", {col_tlast, alpha_u_col}, held);
        if (tready) begin
          stalled = 0; acc++; beats++;
          chk("col_after_hdr", in_frame, 1);
          if (bq.size() == 0) begin
            total++;
            $display("FAIL beat_unexpected: got %0h expected none", alpha_u_col);
          end else begin
            chk("beat", {col_tlast, alpha_u_col}, bq.pop_front());
          end
          if (col_tlast) begin
            chk("beats_per_frame", beats, A);
            in_frame = 0; last_cyc = cyc;
          end
        end else begin
          stalled = 1; stall_cnt++;
          held = {col_tlast, alpha_u_col};
        end
      end
    end
  end

  initial begin
    int a0;
    rst_n = 1'b0; wr_en = 0; wr_commit = 0; wr_j = 0;
    wr_data = 0; wr_H_row = 0; wr_y = 0; tready = 1'b1;
    repeat (3) tick();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hvalid", H_row_tvalid, 0);
    chk("rst_cvalid", col_tvalid, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    // single frame, alpha[j][a] = 16*j + a
    hq.push_back('{h: hdr(8'h00), y: yv(8'h00)});
    bq.push_back({1'b0, 32'h3020_1000});
    bq.push_back({1'b0, 32'h3121_1101});
    bq.push_back({1'b0, 32'h3222_1202});
    bq.push_back({1'b1, 32'h3323_1303});
    write_rows(8'h00);
    commit(8'h00);
    chk("t1_wr_ready", wr_ready, 1);
    repeat (10) tick();
    chk("t1_hdr_lat", hdr_cyc, c_edge + 1);
    chk("t1_last_lat", last_cyc, c_edge + 5);
    chk("t1_cnt", frame_cnt, 1);

    // backpressure on beat 1
    push_frame(8'h40);
    write_rows(8'h40);
    a0 = acc;
    commit(8'h40);
    repeat (3) tick();
    tready = 1'b0;
    repeat (3) tick();
    tready = 1'b1;
    repeat (8) tick();
    chk("bp_stalls", stall_cnt, 3);
    chk("bp_accepted", acc - a0, 4);
    chk("bp_last_lat", last_cyc, c_edge + 8);
    chk("bp_cnt", frame_cnt, 2);

    // ping-pong: second frame written during the first
    push_frame(8'h80);
    push_frame(8'h90);
    write_rows(8'h80);
    commit(8'h80);
    write_rows(8'h90);
    commit(8'h90);
    chk("pp_wr_ready_low", wr_ready, 0);
    chk("pp_ovf_before", overflow, 0);
    commit(8'hEE);
    chk("pp_ovf", overflow, 1);
    repeat (14) tick();
    chk("pp_hdr_gap", hdr_gap, 4);
    chk("pp_cnt", frame_cnt, 4);
    chk("pp_wr_ready_back", wr_ready, 1);

    // out-of-range row index must not touch the bank
    push_frame(8'h50);
    write_rows(8'h50);
    wr_en = 1'b1; wr_j = 3'd4; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_j = 3'd7;
    tick();
    wr_en = 1'b0;
    commit(8'h50);
    repeat (10) tick();
    chk("bnd_cnt", frame_cnt, 5);

    // reset in the middle of a frame
    push_hdr(8'h60);
    bq.push_back({1'b0, col(8'h60, 0)});
    bq.push_back({1'b0, col(8'h60, 1)});
    write_rows(8'h60);
    commit(8'h60);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mr_cvalid", col_tvalid, 0);
    chk("mr_hvalid", H_row_tvalid, 0);
    chk("mr_tlast", col_tlast, 0);
    chk("mr_wr_ready", wr_ready, 1);
    chk("mr_cnt", frame_cnt, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_busy", busy, 0);
    chk("mr_hq_empty", hq.size(), 0);
    chk("mr_bq_empty", bq.size(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_frame(8'h10);
    write_rows(8'h10);
    commit(8'h10);
    repeat (10) tick();
    chk("mr_restart_lat", hdr_cyc, c_edge + 1);
    chk("mr_restart_cnt", frame_cnt, 1);

    // frame counter wrap
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    chk("wrap_pre", frame_cnt, 16'hFFFF);
    push_frame(8'h70);
    write_rows(8'h70);
    commit(8'h70);
    repeat (10) tick();
    chk("wrap_cnt", frame_cnt, 0);

    chk("end_hq_empty", hq.size(), 0);
    chk("end_bq_empty", bq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
